// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR scrub controller.
package tmr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_e;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/tmr_voter.sv
// Single-bit 2-of-3 majority voter.
module tmr_voter (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Votes three replicated lanes, publishes the majority word and scrubs
// disagreeing lanes back over a req/ack port; tracks per-lane health.
module tmr_scrub_ctrl
  import tmr_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 4,
  parameter int ERR_THRESH = 3,
  parameter int ACK_TMO    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lane_a,
  input  logic [WIDTH-1:0] lane_b,
  input  logic [WIDTH-1:0] lane_c,
  input  logic             vote_en,
  input  logic             clr_stats,
  output logic [WIDTH-1:0] voted,
  output logic             valid,
  output logic             busy,
  output logic             scrub_req,
  output logic [1:0]       scrub_lane,
  output logic [WIDTH-1:0] scrub_data,
  input  logic             scrub_ack,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c,
  output logic [2:0]       lane_fail,
  output logic             degraded
);

  localparam int TMO_W = $clog2(ACK_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(ERR_THRESH);

  logic [WIDTH-1:0] maj;
  logic [2:0]       diff_nz;

  for (genvar i = 0; i < WIDTH; i++) begin : g_vote
    tmr_voter u_voter (
      .a (lane_a[i]),
      .b (lane_b[i]),
      .c (lane_c[i]),
      .y (maj[i])
    );
  end

  assign diff_nz = {|(lane_c ^ maj), |(lane_b ^ maj), |(lane_a ^ maj)};

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        voted_q, voted_d;
  logic                    valid_q, valid_d;
  logic [2:0]              pend_q, pend_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [2:0][CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [2:0]              lane_fail_q, lane_fail_d;
  logic                    degraded_q, degraded_d;
  logic [1:0]              cur_lane;
  logic [2:0]              cur_oh;

  // Lane A has priority, then B, then C.
  always_comb begin
    cur_lane = LANE_A;
    cur_oh   = 3'b000;
    if (pend_q[0]) begin
      cur_lane = LANE_A;
      cur_oh   = 3'b001;
    end else if (pend_q[1]) begin
      cur_lane = LANE_B;
      cur_oh   = 3'b010;
    end else if (pend_q[2]) begin
      cur_lane = LANE_C;
      cur_oh   = 3'b100;
    end
  end

  always_comb begin
    state_d     = state_q;
    voted_d     = voted_q;
    valid_d     = 1'b0;
    pend_d      = pend_q;
    tmo_d       = tmo_q;
    err_cnt_d   = err_cnt_q;
    lane_fail_d = lane_fail_q;
    case (state_q)
      IDLE: begin
        if (clr_stats) begin
          err_cnt_d   = '0;
          lane_fail_d = '0;
        end
        if (vote_en) begin
          voted_d = maj;
          valid_d = 1'b1;
          // Failed lanes still accumulate counts but are never scrubbed.
          for (int l = 0; l < 3; l++) begin
            if (diff_nz[l]) begin
              if (err_cnt_d[l] != CNT_MAX) err_cnt_d[l] = err_cnt_d[l] + 1'b1;
              if (err_cnt_d[l] >= THRESH) lane_fail_d[l] = 1'b1;
            end
          end
          pend_d = diff_nz & ~lane_fail_d;
          tmo_d  = '0;
          if (pend_d != 3'b000) state_d = SCRUB;
        end
      end
      SCRUB: begin
        if (scrub_ack) begin
          pend_d = pend_q & ~cur_oh;
          tmo_d  = '0;
        end else if (tmo_q == TMO_LAST) begin
          lane_fail_d = lane_fail_q | cur_oh;
          pend_d      = pend_q & ~cur_oh;
          tmo_d       = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (pend_d == 3'b000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    degraded_d = popcount3(lane_fail_d) >= 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      voted_q     <= '0;
      valid_q     <= 1'b0;
      pend_q      <= '0;
      tmo_q       <= '0;
      err_cnt_q   <= '0;
      lane_fail_q <= '0;
      degraded_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      voted_q     <= voted_d;
      valid_q     <= valid_d;
      pend_q      <= pend_d;
      tmo_q       <= tmo_d;
      err_cnt_q   <= err_cnt_d;
      lane_fail_q <= lane_fail_d;
      degraded_q  <= degraded_d;
    end
  end

  assign voted      = voted_q;
  assign valid      = valid_q;
  assign busy       = (state_q == SCRUB);
  assign scrub_req  = (state_q == SCRUB);
  assign scrub_lane = cur_lane;
  assign scrub_data = voted_q;
  assign err_cnt_a  = err_cnt_q[0];
  assign err_cnt_b  = err_cnt_q[1];
  assign err_cnt_c  = err_cnt_q[2];
  assign lane_fail  = lane_fail_q;
  assign degraded   = degraded_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Randomized bench for tmr_scrub_ctrl against a queue-based behavioural model,
// with directed scenarios pinned by literal expectations.
module tb_tmr_scrub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] lane_a = '0, lane_b = '0, lane_c = '0;
  logic       vote_en = 1'b0, clr_stats = 1'b0, scrub_ack = 1'b0;
  logic [7:0] voted, scrub_data;
  logic       valid, busy, scrub_req, degraded;
  logic [1:0] scrub_lane;
  logic [3:0] err_cnt_a, err_cnt_b, err_cnt_c;
  logic [2:0] lane_fail;

  tmr_scrub_ctrl #(.WIDTH(8), .CNT_W(4), .ERR_THRESH(3), .ACK_TMO(15)) dut (
    .clk(clk), .rst(rst), .lane_a(lane_a), .lane_b(lane_b), .lane_c(lane_c),
    .vote_en(vote_en), .clr_stats(clr_stats), .voted(voted), .valid(valid),
    .busy(busy), .scrub_req(scrub_req), .scrub_lane(scrub_lane),
    .scrub_data(scrub_data), .scrub_ack(scrub_ack), .err_cnt_a(err_cnt_a),
    .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c), .lane_fail(lane_fail),
    .degraded(degraded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;
  int ack_mode = 0;   // 0 never, 1 immediate, 2 random, 3 two cycles after req
  int hold = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_cnt[3];
  bit [2:0]   m_fail;
  bit         m_busy, m_valid, m_deg;
  logic [7:0] m_voted;
  int         m_q[$];
  int         m_wait;
  int         m_tmp;
  logic [7:0] m_mj;
  logic [7:0] m_ln[3];

  always @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < 3; l++) m_cnt[l] = 0;
      m_fail = '0; m_busy = 0; m_valid = 0; m_voted = '0; m_q.delete(); m_wait = 0;
    end else if (!m_busy) begin
      m_valid = 0;
      if (clr_stats) begin
        for (int l = 0; l < 3; l++) m_cnt[l] = 0;
        m_fail = '0;
      end
      if (vote_en) begin
        m_ln[0] = lane_a; m_ln[1] = lane_b; m_ln[2] = lane_c;
        for (int i = 0; i < 8; i++)
          m_mj[i] = (int'(lane_a[i]) + int'(lane_b[i]) + int'(lane_c[i])) >= 2;
        m_voted = m_mj;
        m_valid = 1;
        for (int l = 0; l < 3; l++)
          if (m_ln[l] != m_mj) begin
            if (m_cnt[l] < 15) m_cnt[l]++;
            if (m_cnt[l] >= 3) m_fail[l] = 1'b1;
          end
        for (int l = 0; l < 3; l++)
          if (m_ln[l] != m_mj && !m_fail[l]) m_q.push_back(l);
        m_wait = 0;
        m_busy = (m_q.size() > 0);
      end
    end else begin
      m_valid = 0;
      if (scrub_ack) begin
        m_tmp = m_q.pop_front();
        m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == 15) begin
          m_fail[m_q[0]] = 1'b1;
          m_tmp = m_q.pop_front();
          m_wait = 0;
        end
      end
      m_busy = (m_q.size() > 0);
    end
    m_deg = ($countones(m_fail) >= 2);
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("voted", 32'(voted), 32'(m_voted));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("scrub_req", 32'(scrub_req), 32'(m_busy));
      chk("scrub_lane", 32'(scrub_lane), m_busy ? 32'(m_q[0]) : 32'd0);
      if (m_busy) chk("scrub_data", 32'(scrub_data), 32'(m_voted));
      chk("err_cnt", {20'd0, err_cnt_c, err_cnt_b, err_cnt_a},
          {20'd0, 4'(m_cnt[2]), 4'(m_cnt[1]), 4'(m_cnt[0])});
      chk("lane_fail", 32'(lane_fail), 32'(m_fail));
      chk("degraded", 32'(degraded), 32'(m_deg));
    end
  end

  // ---------------- ack responder ----------------
  always @(posedge clk) begin
    #2;
    case (ack_mode)
      1: scrub_ack = scrub_req;
      2: scrub_ack = ($urandom % 3 == 0);
      3: begin
        if (scrub_req) begin
          if (hold == 2) begin scrub_ack = 1'b1; hold = 0; end
          else begin scrub_ack = 1'b0; hold++; end
        end else begin
          scrub_ack = 1'b0; hold = 0;
        end
      end
      default: scrub_ack = 1'b0;
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic vote(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    lane_a = a; lane_b = b; lane_c = c;
    vote_en = 1'b1;
    step();
    vote_en = 1'b0;
  endtask

  task automatic clr();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  int n;

  initial begin
    rst = 1'b1;
    step(); step();
    cmp_on = 1'b1;
    chk("rst_voted", 32'(voted), 32'd0);
    chk("rst_outs", {busy, scrub_req, valid, degraded, lane_fail, err_cnt_a}, '0);
    rst = 1'b0;
    step();

    // All lanes agree: publish only.
    vote(8'h5A, 8'h5A, 8'h5A);
    chk("agree_voted", 32'(voted), 32'h5A);
    chk("agree_valid", 32'(valid), 32'd1);
    chk("agree_busy", 32'(busy), 32'd0);
    step();
    chk("agree_valid_pulse", 32'(valid), 32'd0);

    // Single faulty lane A, ack two cycles after req.
    ack_mode = 3;
    vote(8'h5B, 8'h5A, 8'h5A);
    chk("a_req", 32'(scrub_req), 32'd1);
    chk("a_lane", 32'(scrub_lane), 32'd0);
    chk("a_data", 32'(scrub_data), 32'h5A);
    chk("a_cnt", 32'(err_cnt_a), 32'd1);
    wait_idle(n);
    chk("a_busy_cycles", 32'(n), 32'd3);

    // Two faulty lanes, back-to-back scrubs.
    clr();
    vote(8'h01, 8'h02, 8'h00);
    chk("ab_voted", 32'(voted), 32'h00);
    chk("ab_first_lane", 32'(scrub_lane), 32'd0);
    step(); step(); step();
    chk("ab_req_held", 32'(scrub_req), 32'd1);
    chk("ab_second_lane", 32'(scrub_lane), 32'd1);
    wait_idle(n);
    chk("ab_busy_cycles", 32'(n), 32'd3);

    // Same lane A fault three times: third vote retires it without a scrub.
    clr();
    ack_mode = 1;
    for (int k = 0; k < 3; k++) begin
      vote(8'h5B, 8'h5A, 8'h5A);
      if (k == 2) begin
        chk("thr_cnt", 32'(err_cnt_a), 32'd3);
        chk("thr_fail", 32'(lane_fail), 32'b001);
        chk("thr_no_scrub", 32'(scrub_req), 32'd0);
      end
      wait_idle(n);
      step();
    end

    // Never ack: timeout retires lanes; two retired lanes -> degraded.
    clr();
    ack_mode = 0;
    vote(8'h5B, 8'h5A, 8'h5A);
    wait_idle(n);
    chk("tmo_cycles", 32'(n), 32'd15);
    chk("tmo_fail_a", 32'(lane_fail), 32'b001);
    chk("tmo_deg0", 32'(degraded), 32'd0);
    vote(8'h5A, 8'h5B, 8'h5A);
    wait_idle(n);
    step();
    chk("tmo_fail_ab", 32'(lane_fail), 32'b011);
    chk("tmo_deg1", 32'(degraded), 32'd1);
    clr();
    chk("clr_fail", 32'(lane_fail), 32'd0);
    chk("clr_deg", 32'(degraded), 32'd0);
    chk("clr_cnt", {err_cnt_c, err_cnt_b, err_cnt_a}, 12'd0);

    // Reset during SCRUB.
    vote(8'h5B, 8'h5A, 8'h5A);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_req", 32'(scrub_req), 32'd0);
    chk("mid_rst_outs", {busy, valid, voted, err_cnt_a, lane_fail}, '0);
    step();
    vote(8'h5A, 8'h5A, 8'h5B);
    chk("post_rst_valid", 32'(valid), 32'd1);
    chk("post_rst_lane", 32'(scrub_lane), 32'd2);
    ack_mode = 1;
    wait_idle(n);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) ack_mode = $urandom % 4;
      rst = ($urandom % 200 == 0);
      if (!busy) begin
        if ($urandom % 3 == 0) begin
          lane_a = 8'($urandom);
          lane_b = lane_a;
          lane_c = lane_a;
          if ($urandom % 3 == 0) lane_a = lane_a ^ 8'($urandom);
          if ($urandom % 3 == 0) lane_b = lane_b ^ 8'($urandom);
          if ($urandom % 4 == 0) lane_c = lane_c ^ 8'($urandom);
        end
        vote_en   = ($urandom % 2 == 0);
        clr_stats = ($urandom % 10 == 0);
      end else begin
        vote_en   = ($urandom % 4 == 0);
        clr_stats = ($urandom % 8 == 0);
      end
      step();
    end
    rst = 1'b0; vote_en = 1'b0; clr_stats = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
